// File: rtl/alu_pipe_pkg.sv
// Shared opcode and operand-stage state definitions for alu_pipe.
// The iterative multiplier is enabled by defining ALU_PIPE_MUL_EN.
package alu_pipe_pkg;

    localparam int OPW_FIXED = 3;

    localparam logic [2:0] OPC_ADD = 3'd0;
    localparam logic [2:0] OPC_SUB = 3'd1;
    localparam logic [2:0] OPC_AND = 3'd2;
    localparam logic [2:0] OPC_OR  = 3'd3;
    localparam logic [2:0] OPC_XOR = 3'd4;
    localparam logic [2:0] OPC_SLL = 3'd5;
    localparam logic [2:0] OPC_SRL = 3'd6;
    localparam logic [2:0] OPC_MUL = 3'd7;

    typedef enum logic [2:0] {
        OP_ADD = OPC_ADD,
        OP_SUB = OPC_SUB,
        OP_AND = OPC_AND,
        OP_OR  = OPC_OR,
        OP_XOR = OPC_XOR,
        OP_SLL = OPC_SLL,
        OP_SRL = OPC_SRL,
        OP_MUL = OPC_MUL
    } op_e;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_FULL     = 2'd1,
        ST_MUL_BUSY = 2'd2
    } state_e;

endpackage

// File: rtl/alu_pipe_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles.
// done stays high from completion until the next start, holding product stable.
module alu_pipe_mul
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand_q, acc_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q, done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            // WIDTH is a power of two, so the counter wraps back to 0 on the last bit
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU: operand stage (EMPTY/FULL/MUL_BUSY FSM) feeding a registered output stage.
// Define ALU_PIPE_MUL_EN to build the iterative multiplier; otherwise opcode 7 yields out=0, carry=1.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [OPW-1:0]   op_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int SHW = $clog2(WIDTH);

    state_e           st_q, st_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [OPW-1:0]   op_q;
    logic [WIDTH-1:0] out_q;
    logic             carry_q, zero_q, ovld_q;

    logic             out_free, xfer, accept, is_mul_in;
    logic [WIDTH-1:0] res_d;
    logic             res_c;
    logic [WIDTH:0]   sum;

    assign out_free = !ovld_q || out_ready;
    assign accept   = in_valid && in_ready;

`ifdef ALU_PIPE_MUL_EN
    logic               mul_busy, mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    assign is_mul_in = (op_in == OPW'(OPC_MUL));
    assign xfer      = out_free && ((st_q == ST_FULL) ||
                                    (st_q == ST_MUL_BUSY && mul_done && !mul_busy));

    alu_pipe_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_mul_in),
        .a       (a_in),
        .b       (b_in),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );
`else
    assign is_mul_in = 1'b0;
    assign xfer      = out_free && (st_q == ST_FULL);
`endif

    // A finishing multiply does not take a new request on the same edge.
    assign in_ready = rst_n && ((st_q == ST_EMPTY) || (st_q == ST_FULL && xfer));

    always_comb begin
        st_d = st_q;
        case (st_q)
            ST_EMPTY: begin
                if (accept) st_d = is_mul_in ? ST_MUL_BUSY : ST_FULL;
            end
            ST_FULL: begin
                if (xfer) begin
                    if (accept) st_d = is_mul_in ? ST_MUL_BUSY : ST_FULL;
                    else        st_d = ST_EMPTY;
                end
            end
`ifdef ALU_PIPE_MUL_EN
            ST_MUL_BUSY: begin
                if (xfer) st_d = ST_EMPTY;
            end
`endif
            default: st_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) st_q <= ST_EMPTY;
        else        st_q <= st_d;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= a_in;
            b_q  <= b_in;
            op_q <= op_in;
        end
    end

    always_comb begin
        res_d = '0;
        res_c = 1'b0;
        sum   = {1'b0, a_q} + {1'b0, b_q};
        case (op_e'(op_q[2:0]))
            OP_ADD: begin
                res_d = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
            end
            OP_SUB: begin
                res_d = a_q - b_q;
                res_c = (a_q < b_q);
            end
            OP_AND: res_d = a_q & b_q;
            OP_OR:  res_d = a_q | b_q;
            OP_XOR: res_d = a_q ^ b_q;
            OP_SLL: res_d = a_q << b_q[SHW-1:0];
            OP_SRL: res_d = a_q >> b_q[SHW-1:0];
            OP_MUL: begin
`ifdef ALU_PIPE_MUL_EN
                res_d = mul_prod[WIDTH-1:0];
                res_c = |mul_prod[2*WIDTH-1:WIDTH];
`else
                // illegal-op marker when the multiplier is not built
                res_d = '0;
                res_c = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            ovld_q  <= 1'b0;
        end else if (xfer) begin
            out_q   <= res_d;
            carry_q <= res_c;
            zero_q  <= (res_d == '0);
            ovld_q  <= 1'b1;
        end else if (out_ready) begin
            ovld_q  <= 1'b0;
        end
    end

    assign out       = out_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign out_valid = ovld_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=32); follows ALU_PIPE_MUL_EN for MUL expectations.
module tb_alu_pipe;

    logic        clk;
    logic        rst_n;
    logic [31:0] a_in, b_in;
    logic [2:0]  op_in;
    logic        in_valid, in_ready;
    logic [31:0] out;
    logic        carry, zero, out_valid, out_ready;

    int checks = 0;
    int errors = 0;

    alu_pipe #(.WIDTH(32), .OPW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_in      (a_in),
        .b_in      (b_in),
        .op_in     (op_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .carry     (carry),
        .zero      (zero),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request; returns edges from accept edge to out_valid and the result seen.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] o, output logic c, output logic z);
        int n;
        @(negedge clk);
        op_in = op; a_in = a; b_in = b; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0; o = '0; c = 1'b0; z = 1'b0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) begin
                o = out; c = carry; z = zero;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a_in = '0; b_in = '0; op_in = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out !== 32'h0) begin errors++; $display("FAIL reset_out: got %h want 0", out); end
        checks++; if (carry !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b want 0", carry); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b want 0", zero); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    endtask

    // First edge out of reset accepts ADD 0xFFFFFFFF+1; result two cycles later.
    task automatic test_first_add;
        @(negedge clk);
        rst_n = 1'b1;
        op_in = 3'd0; a_in = 32'hFFFF_FFFF; b_in = 32'h1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL first_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid: got %b want 0", out_valid); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_latency: out_valid got %b want 1", out_valid); end
        checks++; if (out !== 32'h0) begin errors++; $display("FAIL add_wrap_out: got %h want 0", out); end
        checks++; if (carry !== 1'b1) begin errors++; $display("FAIL add_wrap_carry: got %b want 1", carry); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL add_wrap_zero: got %b want 1", zero); end
    endtask

    task automatic test_alu_ops;
        logic [2:0]  ops  [8];
        logic [31:0] av   [8];
        logic [31:0] bv   [8];
        logic [31:0] eo   [8];
        logic        ec   [8];
        int lat; logic [31:0] o; logic c, z;
        ops[0] = 3'd1; av[0] = 32'd5;          bv[0] = 32'd7;          eo[0] = 32'hFFFF_FFFE; ec[0] = 1'b1;
        ops[1] = 3'd5; av[1] = 32'd1;          bv[1] = 32'd31;         eo[1] = 32'h8000_0000; ec[1] = 1'b0;
        ops[2] = 3'd6; av[2] = 32'h8000_0000;  bv[2] = 32'h25;         eo[2] = 32'h0400_0000; ec[2] = 1'b0;
        ops[3] = 3'd2; av[3] = 32'hF0F0_F0F0;  bv[3] = 32'hFF00_FF00;  eo[3] = 32'hF000_F000; ec[3] = 1'b0;
        ops[4] = 3'd3; av[4] = 32'h0F0F_0000;  bv[4] = 32'h0000_00F0;  eo[4] = 32'h0F0F_00F0; ec[4] = 1'b0;
        ops[5] = 3'd4; av[5] = 32'hAAAA_5555;  bv[5] = 32'hFFFF_0000;  eo[5] = 32'h5555_5555; ec[5] = 1'b0;
        ops[6] = 3'd1; av[6] = 32'd7;          bv[6] = 32'd5;          eo[6] = 32'd2;         ec[6] = 1'b0;
        ops[7] = 3'd0; av[7] = 32'h7FFF_FFFF;  bv[7] = 32'd1;          eo[7] = 32'h8000_0000; ec[7] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idle(2);
            do_op(ops[i], av[i], bv[i], lat, o, c, z);
            checks++; if (lat !== 1) begin errors++; $display("FAIL op%0d_latency: got %0d edges want 1", i, lat); end
            checks++; if (o !== eo[i]) begin errors++; $display("FAIL op%0d_out: got %h want %h", i, o, eo[i]); end
            checks++; if (c !== ec[i]) begin errors++; $display("FAIL op%0d_carry: got %b want %b", i, c, ec[i]); end
            checks++; if (z !== (eo[i] == 32'h0)) begin errors++; $display("FAIL op%0d_zero: got %b want %b", i, z, eo[i] == 32'h0); end
        end
    endtask

    task automatic test_mul;
        int lat; logic [31:0] o; logic c, z;
`ifdef ALU_PIPE_MUL_EN
        idle(2);
        do_op(3'd7, 32'h0001_0000, 32'h0001_0000, lat, o, c, z);
        checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency: got %0d edges want 33", lat); end
        checks++; if (o !== 32'h0) begin errors++; $display("FAIL mul_ovf_out: got %h want 0", o); end
        checks++; if (c !== 1'b1) begin errors++; $display("FAIL mul_ovf_carry: got %b want 1", c); end
        idle(2);
        do_op(3'd7, 32'd3, 32'd5, lat, o, c, z);
        checks++; if (o !== 32'd15) begin errors++; $display("FAIL mul_small_out: got %h want f", o); end
        checks++; if (c !== 1'b0) begin errors++; $display("FAIL mul_small_carry: got %b want 0", c); end
`else
        idle(2);
        do_op(3'd7, 32'h0001_0000, 32'h0001_0000, lat, o, c, z);
        checks++; if (lat !== 1) begin errors++; $display("FAIL illop_latency: got %0d edges want 1", lat); end
        checks++; if (o !== 32'h0) begin errors++; $display("FAIL illop_out: got %h want 0", o); end
        checks++; if (c !== 1'b1) begin errors++; $display("FAIL illop_carry: got %b want 1", c); end
        checks++; if (z !== 1'b1) begin errors++; $display("FAIL illop_zero: got %b want 1", z); end
`endif
    endtask

    // Request k accepted at the edge after negedge k, visible at negedge k+2.
    task automatic test_back_to_back;
        idle(2);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = (k < 10);
            op_in = 3'd0; a_in = 32'(k); b_in = 32'd100;
            #1;
            if (k < 10) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready k=%0d: got %b want 1", k, in_ready); end
            end
            if (k >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out !== 32'(k - 2 + 100)) begin
                    errors++; $display("FAIL b2b_result k=%0d: got v=%b %h want v=1 %h", k, out_valid, out, 32'(k - 2 + 100));
                end
            end else begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_early k=%0d: got %b want 0", k, out_valid); end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure;
        int acc, rcv;
        logic [31:0] prev;
        logic prev_v;
        idle(2);
        acc = 0; rcv = 0; prev = '0; prev_v = 1'b0;
        for (int k = 0; k < 60 && rcv < 6; k++) begin
            @(negedge clk);
            out_ready = (k >= 5);
            in_valid = (acc < 6);
            op_in = 3'd0; a_in = 32'(acc * 3); b_in = 32'd1000;
            #1;
            if (k == 5) begin
                checks++; if (acc !== 2) begin errors++; $display("FAIL bp_accepts_before_release: got %0d want 2", acc); end
            end
            if (k >= 2 && k <= 4) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready k=%0d: got %b want 0", k, in_ready); end
            end
            if (out_valid && !out_ready) begin
                if (prev_v) begin
                    checks++; if (out !== prev) begin errors++; $display("FAIL bp_stable k=%0d: got %h want %h", k, out, prev); end
                end
                prev = out; prev_v = 1'b1;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out !== 32'(rcv * 3 + 1000)) begin
                    errors++; $display("FAIL bp_order r=%0d: got %h want %h", rcv, out, 32'(rcv * 3 + 1000));
                end
                rcv++; prev_v = 1'b0;
            end
            if (in_valid && in_ready) acc++;
        end
        in_valid = 1'b0;
        checks++; if (rcv !== 6) begin errors++; $display("FAIL bp_delivered: got %0d want 6", rcv); end
    endtask

    task automatic test_reset_mid;
        int lat; logic [31:0] o; logic c, z;
        logic seen;
        idle(2);
        @(negedge clk);
`ifdef ALU_PIPE_MUL_EN
        op_in = 3'd7; a_in = 32'd9; b_in = 32'd9;
`else
        op_in = 3'd0; a_in = 32'd9; b_in = 32'd9;
`endif
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
`ifdef ALU_PIPE_MUL_EN
        repeat (5) @(negedge clk);
`else
        @(negedge clk);
`endif
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready_low: got %b want 0", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk); #1;
            seen = seen | out_valid;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_discard: out_valid seen %b want 0", seen); end
        do_op(3'd0, 32'd2, 32'd3, lat, o, c, z);
        checks++; if (lat !== 1) begin errors++; $display("FAIL rstmid_add_latency: got %0d want 1", lat); end
        checks++; if (o !== 32'd5) begin errors++; $display("FAIL rstmid_add_out: got %h want 5", o); end
    endtask

    initial begin
        test_reset();
        test_first_add();
        test_alu_ops();
        test_mul();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; power of two, >= 8.
REQ-002 SHALL have parameter OPW, default 3, opcode width (fixed at 3 for this release).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port a_in  input  WIDTH  operand A.
REQ-006 SHALL have port b_in  input  WIDTH  operand B (shift amount = low log2(WIDTH) bits).
REQ-007 SHALL have port op_in  input  OPW  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 MUL.
REQ-008 SHALL have port in_valid  input  1  request valid.
REQ-009 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready at a rising edge.
REQ-010 SHALL have port out  output  WIDTH  registered result.
REQ-011 SHALL have port carry  output  1  ADD carry-out, SUB borrow (a<b unsigned), MUL overflow, else 0.
REQ-012 SHALL have port zero  output  1  out == 0.
REQ-013 SHALL have port out_valid  output  1  result valid.
REQ-014 SHALL have port out_ready  input  1  consumer accepts result when out_valid && out_ready at a rising edge.

Function
REQ-015 SHALL implement two stages: operand stage (FSM) and output register stage.
REQ-016 Operand-stage FSM SHALL have states EMPTY, FULL, MUL_BUSY; reset state EMPTY.
REQ-017 EMPTY: on accept, non-MUL op -> FULL, MUL op -> MUL_BUSY; operands and opcode captured.
REQ-018 FULL: when output stage empty or out_ready=1, result SHALL move to output stage; next state FULL if a new request is accepted same edge, else EMPTY.
REQ-019 MUL_BUSY: iterative shift-add, one multiplier bit per cycle, WIDTH cycles, then FULL-equivalent transfer rules apply.
REQ-020 in_ready SHALL be 1 in EMPTY, or in FULL when the transfer of REQ-018 occurs this cycle; 0 in MUL_BUSY and while rst_n=0.
REQ-021 Non-MUL latency SHALL be 2 cycles (accept cycle c -> out_valid in c+2); throughput 1/cycle with out_ready held 1.
REQ-022 MUL latency SHALL be WIDTH+2 cycles without backpressure; out = low WIDTH bits of product; carry = OR of upper WIDTH bits.
REQ-023 ADD/SUB SHALL wrap modulo 2^WIDTH; SLL/SRL logical, shift by b_in[log2(WIDTH)-1:0], carry 0.
REQ-024 out, carry, zero SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 No request SHALL be dropped or duplicated under any in_valid/out_ready pattern.

Reset
REQ-026 While rst_n=0 at a rising edge: out=0, carry=0, zero=0, out_valid=0, FSM=EMPTY, multiplier counter=0.
REQ-027 Reset mid-MUL or with result pending SHALL discard the operation; no out_valid follows.
REQ-028 First request SHALL be accepted on the first edge with rst_n=1 if in_valid=1.

Configuration
REQ-029 Macro ALU_PIPE_MUL_EN SHALL compile in the iterative multiplier and MUL_BUSY state.
REQ-030 Without ALU_PIPE_MUL_EN, opcode 7 SHALL complete with non-MUL latency, out=0, carry=1 (illegal-op marker), zero=1.

Structure
REQ-031 Package alu_pipe_pkg SHALL hold opcode enum, FSM state typedef, and opcode localparams.
REQ-032 Iterative multiplier SHALL be sub-module alu_pipe_mul (start, busy, done, product) instantiated only under ALU_PIPE_MUL_EN.

Verification
REQ-033 WIDTH=32, ADD 0xFFFFFFFF+1, out_ready=1 -> out=0, carry=1, zero=1, out_valid 2 cycles after accept.
REQ-034 SUB 5-7 -> out=0xFFFFFFFE, carry=1; SLL 1<<31 -> 0x80000000; SRL with b=0x25 -> shift by 5.
REQ-035 10 back-to-back ADDs, out_ready=1 -> 10 results on consecutive cycles, in_ready never 0.
REQ-036 out_ready=0 for 5 cycles with stream in flight -> in_ready drops after 2 accepts, out stable, all results delivered in order after release.
REQ-037 MUL 0x10000*0x10000 (MUL_EN) -> out=0, carry=1 at accept+34; without MUL_EN -> out=0, carry=1 at accept+2.
REQ-038 rst_n=0 for 1 cycle during MUL_BUSY -> out_valid stays 0, in_ready=1 next cycle, next ADD 2+3 -> 5.
